// File: rtl/fp_addsub_pkg.sv
// Shared flag indices, operand classes and special-value constructors for fp_addsub_pipe.
// Constructors return 64-bit patterns; callers truncate to their own word width.
package fp_addsub_pkg;

  localparam int FLAG_INVALID = 3;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_INEXACT = 1;
  localparam int FLAG_ZERO    = 0;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_FIN  = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  function automatic logic [63:0] inf_bits(input logic sign, input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    if (sign) r = r | (64'd1 << (exp_w + man_w));
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter, purely combinational; all-zero input returns 0 (callers
// detect zero separately). No state, no backpressure.
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt
);

  logic found;

  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt   = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Streaming FP add/sub (align -> add/normalise -> RNE round), flush-to-zero, 1 result/cycle.
// Latency 3 edges from accept; whole pipe freezes while out_valid & ~out_ready.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  input  logic                 Op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] Result,
  output logic [3:0]           Flags
);
  import fp_addsub_pkg::*;

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;  // hidden + fraction + guard + round + sticky
  localparam int LZW = $clog2(SW);
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic [31:0]      SAT       = 32'(MAN_W + 3);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [XW-1:0]    EXP_MAX_X = {{(XW-EXP_W){1'b0}}, EXP_ONES};
  localparam logic [W-1:0]     QNAN      = W'(qnan_bits(EXP_W, MAN_W));

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
    logic             sign;
    logic             zsign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sig_x;
    logic [SW-1:0]    sig_y;
  } s1_t;

  typedef struct packed {
    logic          spec;
    logic [W-1:0]  spec_res;
    logic [3:0]    spec_flg;
    logic          sign;
    logic          is_zero;
    logic [XW-1:0] exp;   // two's complement, may go <= 0 before underflow check
    logic [SW-1:0] norm;
  } s2_t;

  function automatic fp_cls_e cls_of(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)            return CLS_ZERO;
    else if (e == EXP_ONES) return (f == '0) ? CLS_INF : CLS_NAN;
    else                    return CLS_FIN;
  endfunction

  logic v1, v2, v3, stall;
  s1_t  s1_n, s1_q;
  s2_t  s2_n, s2_q;

  assign stall     = v3 & ~out_ready;
  assign in_ready  = Reset & ~stall;
  assign out_valid = v3;

  // ---------------- stage 1: classify, swap, align ----------------
  logic               sa, sb, sx, eff;
  logic [EXP_W-1:0]   ea, eb, ex, ey, d;
  logic [MAN_W-1:0]   fa, fb, fx, fy;
  fp_cls_e            ca, cb, cx, cy;
  logic [W-2:0]       mag_a, mag_b;
  logic [2*MAN_W+3:0] wide_y, shf_y;
  logic               sticky;

  always_comb begin
    sa = A[W-1];
    ea = A[W-2:MAN_W];
    fa = A[MAN_W-1:0];
    sb = B[W-1] ^ Op;
    eb = B[W-2:MAN_W];
    fb = B[MAN_W-1:0];
    ca = cls_of(ea, fa);
    cb = cls_of(eb, fb);
    eff   = sa ^ sb;
    mag_a = (ca == CLS_ZERO) ? '0 : {ea, fa};
    mag_b = (cb == CLS_ZERO) ? '0 : {eb, fb};
    if (mag_a >= mag_b) begin
      sx = sa; ex = ea; fx = fa; cx = ca; ey = eb; fy = fb; cy = cb;
    end else begin
      sx = sb; ex = eb; fx = fb; cx = cb; ey = ea; fy = fa; cy = ca;
    end
    d      = ex - ey;
    wide_y = (cy == CLS_ZERO) ? '0 : {1'b1, fy, {(MAN_W+3){1'b0}}};
    // The low MAN_W+1 bits of the wide vector catch everything shifted past round.
    if (32'(d) > SAT) begin
      shf_y  = '0;
      sticky = |wide_y;
    end else begin
      shf_y  = wide_y >> d;
      sticky = |shf_y[MAN_W:0];
    end

    s1_n          = '0;
    s1_n.sign     = sx;
    s1_n.zsign    = sa & sb;
    s1_n.eff_sub  = eff;
    s1_n.exp      = ex;
    s1_n.sig_x    = (cx == CLS_ZERO) ? '0 : {1'b1, fx, 3'b000};
    s1_n.sig_y    = {shf_y[2*MAN_W+3:MAN_W+1], sticky};
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_res = QNAN;
    end else if (ca == CLS_INF && cb == CLS_INF && eff) begin
      s1_n.spec                   = 1'b1;
      s1_n.spec_res               = QNAN;
      s1_n.spec_flg[FLAG_INVALID] = 1'b1;
    end else if (ca == CLS_INF) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_res = W'(inf_bits(sa, EXP_W, MAN_W));
    end else if (cb == CLS_INF) begin
      s1_n.spec     = 1'b1;
      s1_n.spec_res = W'(inf_bits(sb, EXP_W, MAN_W));
    end
  end

  // ---------------- stage 2: add/sub and normalise ----------------
  logic [SW:0]    sum;
  logic [LZW-1:0] lz;
  logic [XW-1:0]  e_ext;

  fp_lzc #(.WIDTH(SW), .CW(LZW)) u_lzc (
    .din (sum[SW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    e_ext = XW'(s1_q.exp);
    sum   = s1_q.eff_sub ? ({1'b0, s1_q.sig_x} - {1'b0, s1_q.sig_y})
                         : ({1'b0, s1_q.sig_x} + {1'b0, s1_q.sig_y});
    s2_n          = '0;
    s2_n.spec     = s1_q.spec;
    s2_n.spec_res = s1_q.spec_res;
    s2_n.spec_flg = s1_q.spec_flg;
    s2_n.is_zero  = (sum == '0);
    s2_n.sign     = s2_n.is_zero ? s1_q.zsign : s1_q.sign;
    if (sum[SW]) begin
      s2_n.norm = {sum[SW:2], |sum[1:0]};
      s2_n.exp  = e_ext + XW'(1);
    end else begin
      s2_n.norm = sum[SW-1:0] << lz;
      s2_n.exp  = e_ext - XW'(lz);
    end
  end

  // ---------------- stage 3: round to nearest even ----------------
  logic               g, r, s, inc, underflow;
  logic [MAN_W+1:0]   mant;
  logic [XW-1:0]      exp_r;
  logic [MAN_W-1:0]   frac_r;
  logic [W-1:0]       res_n;
  logic [3:0]         flg_n;

  always_comb begin
    g         = s2_q.norm[2];
    r         = s2_q.norm[1];
    s         = s2_q.norm[0];
    inc       = g & (r | s | s2_q.norm[3]);
    mant      = {1'b0, s2_q.norm[SW-1:3]} + (MAN_W+2)'(inc);
    exp_r     = s2_q.exp + XW'(mant[MAN_W+1]);
    frac_r    = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    underflow = s2_q.exp[XW-1] | (s2_q.exp == '0);
    res_n     = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};
    flg_n     = '0;
    if (s2_q.spec) begin
      res_n = s2_q.spec_res;
      flg_n = s2_q.spec_flg;
    end else if (s2_q.is_zero) begin
      res_n            = {s2_q.sign, {(W-1){1'b0}}};
      flg_n[FLAG_ZERO] = 1'b1;
    end else if (underflow) begin
      res_n               = {s2_q.sign, {(W-1){1'b0}}};
      flg_n[FLAG_ZERO]    = 1'b1;
      flg_n[FLAG_INEXACT] = 1'b1;
    end else if (exp_r >= EXP_MAX_X) begin
      res_n               = W'(inf_bits(s2_q.sign, EXP_W, MAN_W));
      flg_n[FLAG_OVF]     = 1'b1;
      flg_n[FLAG_INEXACT] = 1'b1;
    end else begin
      flg_n[FLAG_INEXACT] = g | r | s;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      Result <= '0;
      Flags  <= '0;
    end else if (!stall) begin
      v1   <= in_valid & in_ready;
      v2   <= v1;
      v3   <= v2;
      s1_q <= s1_n;
      s2_q <= s2_n;
      if (v2) begin
        Result <= res_n;
        Flags  <= flg_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: binary32 vector table, stall/stream and reset
// sequences, plus a binary16 instance.
module tb_fp_addsub_pipe;

  logic        Clk = 1'b0;
  logic        Reset, in_valid, in_ready, Op, out_valid, out_ready;
  logic [31:0] A, B, Result;
  logic [3:0]  Flags;

  logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_res;
  logic [3:0]  h_flags;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  fp_addsub_pipe dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Flags(Flags)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .Clk(Clk), .Reset(Reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .A(h_a), .B(h_b), .Op(h_op), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .Result(h_res), .Flags(h_flags)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] er, input logic [3:0] ef, input string name);
    int edges;
    A = a; B = b; Op = op; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge Clk);
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge Clk); #1;
      edges++;
    end
    check({name, " latency"}, 32'(edges), 32'd3);
    check({name, " result"}, Result, er);
    check({name, " flags"}, 32'(Flags), 32'(ef));
    @(posedge Clk); #1;
  endtask

  task automatic run_half(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input logic [15:0] er, input logic [3:0] ef, input string name);
    int edges;
    h_a = a; h_b = b; h_op = op; h_in_valid = 1'b1; h_out_ready = 1'b1;
    @(posedge Clk); #1;
    h_in_valid = 1'b0;
    edges = 1;
    while (!h_out_valid && edges < 10) begin
      @(posedge Clk); #1;
      edges++;
    end
    check({name, " latency"}, 32'(edges), 32'd3);
    check({name, " result"}, 32'(h_res), 32'(er));
    check({name, " flags"}, 32'(h_flags), 32'(ef));
    @(posedge Clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_b[6];
    logic [31:0] s_exp[6];
    logic [31:0] got_q[$];
    logic [31:0] r;
    logic        acc, take;
    int          sent, n;

    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Op = 1'b0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_op = 1'b0;

    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "1+2"});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001, "1-1"});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001, "-0+-0"});
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0001, "0+-0"});
    vecs.push_back('{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0001, "-1+1"});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, "inf+-inf"});
    vecs.push_back('{32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 4'b1000, "-inf--inf"});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000, "inf--inf"});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "nan+1"});
    vecs.push_back('{32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 4'b0000, "1+-nan"});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, "inf+1"});
    vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "1-inf"});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0110, "max+max"});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010, "tie_even"});
    vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010, "tie_odd"});
    vecs.push_back('{32'h4B800000, 32'h3F800001, 1'b0, 32'h4B800001, 4'b0010, "above_half"});
    vecs.push_back('{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0010, "sticky_only"});
    vecs.push_back('{32'h3FFFFFFF, 32'h3F800000, 1'b0, 32'h40400000, 4'b0010, "carry_round"});
    vecs.push_back('{32'h4B7FFFFF, 32'h3F000000, 1'b0, 32'h4B800000, 4'b0010, "round_ovf_sig"});
    vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "3-1"});
    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, "1-2"});
    vecs.push_back('{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, "denorm_ftz"});
    vecs.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, "underflow"});
    vecs.push_back('{32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 4'b0000, "1+-0"});

    repeat (3) @(posedge Clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", Result, 32'd0);
    check("reset flags", 32'(Flags), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    foreach (vecs[i]) run_one(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg, vecs[i].name);

    // Six back-to-back beats of 1.0 + k against a stalled consumer.
    s_b   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    s_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    sent = 0;
    Op = 1'b0;
    for (int c = 0; c < 60 && got_q.size() < 6; c++) begin
      out_ready = (c >= 8);
      in_valid  = (sent < 6);
      A = 32'h3F800000;
      B = s_b[(sent < 6) ? sent : 0];
      @(negedge Clk);
      acc  = in_valid & in_ready;
      take = out_valid & out_ready;
      r    = Result;
      if (c == 7) begin
        check("stream accepts before stall", 32'(sent), 32'd3);
        check("stream in_ready while stalled", 32'(in_ready), 32'd0);
        check("stream held result", Result, s_exp[0]);
      end
      @(posedge Clk); #1;
      if (acc) sent++;
      if (take) got_q.push_back(r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream result count", 32'(got_q.size()), 32'd6);
    foreach (got_q[k]) check($sformatf("stream result %0d", k), got_q[k], s_exp[k]);
    n = 0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (out_valid) n++;
    end
    check("stream no duplicates", 32'(n), 32'd0);

    // Reset with two operations in flight.
    A = 32'h3F800000; B = 32'h40000000; Op = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("midreset in_ready", 32'(in_ready), 32'd0);
    @(posedge Clk); #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset result", Result, 32'd0);
    check("midreset flags", 32'(Flags), 32'd0);
    Reset = 1'b1;
    in_valid = 1'b0;
    n = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (out_valid) n++;
    end
    check("midreset discarded", 32'(n), 32'd0);

    run_half(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000, "h 1+1");
    run_half(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0110, "h max+max");
    run_half(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0001, "h 1-1");
    run_half(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000, "h inf+-inf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised IEEE-754-style floating-point adder/subtractor for any exponent/mantissa width (default binary32).
- Three-stage pipeline: align, add+normalise, round-to-nearest-even.
- Adds a per-operation add/sub select, full special-value handling, exception flags and valid/ready backpressure.
- Used wherever datapath blocks need a streaming FP add at one result per cycle.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width, hidden bit excluded (>=2)
(derived) W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous reset, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
A  in  W  operand A {sign, exp, frac}
B  in  W  operand B
Op  in  1  0 = A+B, 1 = A-B
out_valid  out  1  Result/Flags valid
out_ready  in  1  consumer accepts result
Result  out  W  sum/difference
Flags  out  4  {invalid, overflow, inexact, zero}

Behaviour:
- Reset (Reset==0 at edge): all stage-valid bits 0, Result=0, Flags=0, out_valid=0. Any in-flight operations are discarded.
- in_ready is forced 0 while Reset is low.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - A beat is accepted when in_valid & in_ready.
  - When not stalled, all stages advance together.
  - Latency is exactly 3 cycles from the accept edge to out_valid.
  - Throughput is 1 per cycle. At most 3 operations are in flight.
  - Bubbles travel as invalid stages.
  - Result and Flags stay stable while out_valid & ~out_ready.
  - Order is preserved; no loss or duplication.
- Denormals: flush-to-zero. An input with exp==0 is treated as signed zero. A result whose normalised exp would be <=0 becomes signed zero with inexact=1.
- Stage 1 (align):
  - Unpack and classify each operand as zero, finite, inf or NaN.
  - Effective B sign sB' = sB^Op; effective subtraction eff = sA^sB'.
  - Swap so operand X has the larger magnitude (compare exp, then frac).
  - Shift the smaller significand right by d = eX-eY, saturated at MAN_W+3.
  - Keep guard and round bits; sticky = OR of all bits shifted past round.
- Stage 2 (add/normalise):
  - Compute the (MAN_W+4)-bit sum or difference with a carry bit.
  - On carry: shift right 1, fold the lost bit into sticky, exp+1.
  - Otherwise: shift left by the leading-zero count, exp-lzc.
  - Exact zero difference gives +0, except (-0)+(-0) or equivalent, which gives -0.
- Stage 3 (round):
  - RNE: increment when G & (R | S | LSB).
  - If the increment overflows the significand, shift right and exp+1.
  - inexact = G|R|S (before rounding).
  - If exp reaches all-ones: ±Inf, overflow=1, inexact=1.
- Specials (override the arithmetic path, carried in stage registers):
  - Any NaN input gives canonical qNaN {0, all-ones, 1, zeros}, invalid=0.
  - Inf with effective subtraction against Inf gives qNaN, invalid=1.
  - Inf ± finite or zero gives that Inf.
  - zero flag = 1 whenever Result is ±0.

Decomposition:
- Package fp_addsub_pkg:
  - Flag bit indices (INVALID=3, OVF=2, INEXACT=1, ZERO=0).
  - Class encoding (2-bit: ZERO, FIN, INF, NAN).
  - Canonical-qNaN and signed-Inf constructor functions parametrised by EXP_W/MAN_W.
- Sub-module fp_lzc: parametrised leading-zero counter, combinational, width MAN_W+4, output clog2 width. Instantiated once in stage 2.

Test Plan:
- 0x3F800000 + 0x40000000, Op=0 -> out_valid 3 cycles later, Result 0x40400000, Flags 0000.
- 0x3F800000 with Op=1 minus 0x3F800000 -> 0x00000000, Flags 0001. Also 0x80000000 + 0x80000000 -> 0x80000000, Flags 0001.
- 0x7F800000 + 0xFF800000 -> 0x7FC00000, Flags 1000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000, Flags 0000.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, Flags 0110.
- RNE ties:
  - 0x3F800000 + 0x33800000 -> 0x3F800000, Flags 0010.
  - 0x3F800001 + 0x33800000 -> 0x3F800002, Flags 0010.
- Stream and reset:
  - Send 6 back-to-back beats with out_ready held 0 -> in_ready drops after 3 accepts; release -> 6 results in order, no duplicates.
  - Assert Reset mid-stream -> next cycle out_valid=0, Result=0.
  - Rerun with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> 0x4000.
